polyarith_addrgen_mc: RTL

Multi-source address generator and write-back sequencer for coefficient-wise polynomial arithmetic (ADD, SUB, MUL, MAC) on the PE-wide coefficient BRAM. It sits between the top-level control FSM and the BRAM/BFU datapath. It takes a start command and streams source read addresses with an operand select. It then emits the matching destination write addresses after the fixed datapath latency. It replaces the fixed two-operand generator with a runtime-selectable operand count, a stall input, an explicit write-back stream and a start/busy/done handshake.

---
 rtl/polyarith_pkg.sv | 30 +++
 rtl/polyarith_addrgen_mc_if.sv | 50 +++++
 rtl/polyarith_delay_en.sv | 31 +++
 rtl/polyarith_addrgen_mc.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/polyarith_pkg.sv
// polyarith_pkg
// Shared types and helpers for the polynomial-arithmetic address generator.
//   op_e    : command opcode (ADD, SUB, MUL, MAC = a*b+c)
//   state_e : sequencer state
//   wb_lat  : read-to-write-back latency of the BRAM/BFU datapath
package polyarith_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_MAC = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  // Butterfly type names are carried as packed 8-character strings.
  localparam logic [63:0] BTF_GS = "gs";

  // The GS butterfly adds two pipeline stages.
  function automatic int wb_lat(input int bfu_lat, input int shuffler_lat,
                                input int bram_rd_lat, input logic [63:0] btf_type);
    return 3 + bfu_lat + shuffler_lat + bram_rd_lat + ((btf_type == BTF_GS) ? 2 : 0);
  endfunction

endpackage

// File: rtl/polyarith_addrgen_mc_if.sv
// polyarith_addrgen_mc_if
// Command / read-stream / write-back bus between the control FSM (master)
// and the address generator (slave).
//   start, opcode, poly_base, poly_base_dst, [num_batch], stall : master -> slave
//   busy, rd_valid, rd_addr, rd_sel, wr_valid, wr_addr, done     : slave -> master
// Optional: POLYARITH_BATCH_EN adds num_batch (and the BW parameter).
interface polyarith_addrgen_mc_if #(
  parameter int AW      = 4,
  parameter int NUM_SRC = 3
`ifdef POLYARITH_BATCH_EN
  , parameter int BW    = 3
`endif
);
  import polyarith_pkg::*;

  localparam int SELW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic                         start;
  op_e                          opcode;
  logic [NUM_SRC-1:0][AW-1:0]   poly_base;
  logic [AW-1:0]                poly_base_dst;
`ifdef POLYARITH_BATCH_EN
  logic [BW-1:0]                num_batch;
`endif
  logic                         stall;
  logic                         busy;
  logic                         rd_valid;
  logic [AW-1:0]                rd_addr;
  logic [SELW-1:0]              rd_sel;
  logic                         wr_valid;
  logic [AW-1:0]                wr_addr;
  logic                         done;

  modport master (
`ifdef POLYARITH_BATCH_EN
    output num_batch,
`endif
    output start, opcode, poly_base, poly_base_dst, stall,
    input  busy, rd_valid, rd_addr, rd_sel, wr_valid, wr_addr, done
  );

  modport slave (
`ifdef POLYARITH_BATCH_EN
    input  num_batch,
`endif
    input  start, opcode, poly_base, poly_base_dst, stall,
    output busy, rd_valid, rd_addr, rd_sel, wr_valid, wr_addr, done
  );

endinterface

// File: rtl/polyarith_delay_en.sv
// polyarith_delay_en
// Enable-gated shift register with asynchronous clear; carries the
// {valid, addr} write-back token from the read stream to the write port.
//   clk, rst_n : clock, async active-low clear
//   en         : shift enable (low freezes every stage)
//   d / q      : stage input / last-stage output (DEPTH cycles later)
module polyarith_delay_en #(
  parameter int DEPTH = 3,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else if (en) begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/polyarith_addrgen_mc.sv
// polyarith_addrgen_mc
// Multi-source address generator and write-back sequencer for
// coefficient-wise ADD/SUB/MUL/MAC on the coefficient BRAM.
//   clk, rst_n : clock, async active-low reset (aborts a command, no done)
//   bus        : polyarith_addrgen_mc_if.slave (command, read stream, write stream)
// Optional: POLYARITH_BATCH_EN repeats a command over num_batch polynomials.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; start latches opcode, bases and K
// S_RUN   | one source read per unstalled cycle, D*K reads per batch
// S_DRAIN | reads done, waiting WB_LAT cycles for the last write-back
module polyarith_addrgen_mc
  import polyarith_pkg::*;
#(
  parameter int          LOGN         = 8,
  parameter int          PE           = 8,
  parameter int          NUM_POLY     = 4,
  parameter int          NUM_SRC      = 3,
  parameter logic [63:0] BTF_TYPE     = "unified",
  parameter int          BFU_LAT      = 0,
  parameter int          SHUFFLER_LAT = 0,
  parameter int          BRAM_RD_LAT  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  polyarith_addrgen_mc_if.slave bus
);

  localparam int  N       = 2 ** LOGN;
  localparam int  D       = N / 2 / PE;
  localparam int  CW      = $clog2(D);
  localparam int  AW      = $clog2(NUM_POLY * D);
  localparam int  SELW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int  BW      = $clog2(NUM_POLY) + 1;
  localparam int  WB_LAT  = wb_lat(BFU_LAT, SHUFFLER_LAT, BRAM_RD_LAT, BTF_TYPE);
  localparam int  DCW     = $clog2(WB_LAT + 1);
  localparam bit  HAS_MAC = (NUM_SRC >= 3);

  // SUB reads the minuend source first so the datapath sees (src1, src0).
  function automatic logic [1:0] src_of(input op_e op, input logic [1:0] idx);
    if (op == OP_SUB) return (idx == 2'd0) ? 2'd1 : 2'd0;
    return idx;
  endfunction

  state_e                     state_q, state_d;
  op_e                        op_q, op_d;
  logic [1:0]                 klast_q, klast_d;
  logic [NUM_SRC-1:0][AW-1:0] base_q, base_d;
  logic [AW-1:0]              dst_q, dst_d;
  logic [BW-1:0]              nb_last_q, nb_last_d;
  logic [CW-1:0]              addr_q, addr_d;
  logic [1:0]                 idx_q, idx_d;
  logic [BW-1:0]              batch_q, batch_d;
  logic [DCW-1:0]             drain_q, drain_d;
  logic                       done_q, done_d;
  logic                       rd_valid_q, rd_valid_d;
  logic [AW-1:0]              rd_addr_q, rd_addr_d;
  logic [SELW-1:0]            rd_sel_q, rd_sel_d;
  logic                       rd_last_q, rd_last_d;
  logic [AW-1:0]              rd_dst_q, rd_dst_d;
  logic [1:0]                 src_d;
  logic [AW-1:0]              sel_base, off_d;
  logic                       last_read;
  logic [AW:0]                dly_q;

  assign last_read = (idx_q == klast_q) && (addr_q == CW'(D - 1)) && (batch_q == nb_last_q);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    klast_d    = klast_q;
    base_d     = base_q;
    dst_d      = dst_q;
    nb_last_d  = nb_last_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    batch_d    = batch_q;
    drain_d    = drain_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          op_d    = (bus.opcode == OP_MAC && !HAS_MAC) ? OP_MUL : bus.opcode;
          klast_d = (op_d == OP_MAC) ? 2'd2 : 2'd1;
          base_d  = bus.poly_base;
          dst_d   = bus.poly_base_dst;
`ifdef POLYARITH_BATCH_EN
          nb_last_d = (bus.num_batch == '0) ? '0 : bus.num_batch - BW'(1);
`else
          nb_last_d = '0;
`endif
          addr_d     = '0;
          idx_d      = '0;
          batch_d    = '0;
          rd_valid_d = 1'b1;
        end
      end
      S_RUN: begin
        if (last_read) begin
          state_d = S_DRAIN;
          drain_d = DCW'(WB_LAT);
        end else begin
          rd_valid_d = 1'b1;
          if (idx_q == klast_q) begin
            idx_d = '0;
            if (addr_q == CW'(D - 1)) begin
              addr_d  = '0;
              batch_d = batch_q + BW'(1);
            end else begin
              addr_d = addr_q + CW'(1);
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_DRAIN: begin
        // Terminal count 1: the last write-back is on the bus this cycle.
        if (drain_q == DCW'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - DCW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    src_d    = src_of(op_d, idx_d);
    sel_base = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (src_d == 2'(s)) sel_base = base_d[s];
    end
    // Batches are contiguous, so the per-batch base advance folds into {batch, addr}.
    off_d = AW'({batch_d, addr_d});

    rd_addr_d = rd_addr_q;
    rd_sel_d  = rd_sel_q;
    rd_last_d = rd_last_q;
    rd_dst_d  = rd_dst_q;
    if (rd_valid_d) begin
      rd_addr_d = sel_base + off_d;
      rd_sel_d  = SELW'(src_d);
      rd_last_d = (idx_d == klast_d);
      rd_dst_d  = dst_d + off_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_ADD;
      klast_q    <= 2'd1;
      base_q     <= '0;
      dst_q      <= '0;
      nb_last_q  <= '0;
      addr_q     <= '0;
      idx_q      <= '0;
      batch_q    <= '0;
      drain_q    <= '0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_sel_q   <= '0;
      rd_last_q  <= 1'b0;
      rd_dst_q   <= '0;
    end else if (!bus.stall) begin
      state_q    <= state_d;
      op_q       <= op_d;
      klast_q    <= klast_d;
      base_q     <= base_d;
      dst_q      <= dst_d;
      nb_last_q  <= nb_last_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      batch_q    <= batch_d;
      drain_q    <= drain_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_addr_q  <= rd_addr_d;
      rd_sel_q   <= rd_sel_d;
      rd_last_q  <= rd_last_d;
      rd_dst_q   <= rd_dst_d;
    end
  end

  // Fed from the registered read stage so the write lands WB_LAT cycles
  // after the visible last read of its address.
  polyarith_delay_en #(
    .DEPTH (WB_LAT),
    .W     (AW + 1)
  ) u_wb_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!bus.stall),
    .d     ({rd_valid_q & rd_last_q, rd_dst_q}),
    .q     (dly_q)
  );

  // A stalled cycle holds all state but must not present a transfer.
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.rd_valid = rd_valid_q & ~bus.stall;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.rd_sel   = rd_sel_q;
  assign bus.wr_valid = dly_q[AW] & ~bus.stall;
  assign bus.wr_addr  = dly_q[AW-1:0];
  assign bus.done     = done_q & ~bus.stall;

endmodule
